// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers.
// Gray/binary conversions work on zero-extended values, so callers of any
// pointer width up to 32 bits cast their operand in and truncate the result.
package fifo_pkg;

    localparam int FUNC_W = 32;

    // Pointer width for a given depth: one address bit more than the memory
    // index, so that full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it. Shared with the read-side controller.
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO.
// Gates producer writes, keeps binary and Gray write pointers, and derives
// full / almost_full / level / overflow from the synchronized read pointer.
module async_fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    input  logic                  ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  overflow
);

    localparam int A  = ADDR_WIDTH;
    localparam int PW = ptr_width(FIFO_DEPTH);

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_gray;
    logic          r_full;
    logic          r_afull;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_full_ptr;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;

    gray2bin_conv #(.W(PW)) u_rd_g2b (
        .i_gray (rd_ptr_gray_sync),
        .o_bin  (w_rd_bin)
    );

    // A write is accepted only while the registered full flag is low.
    assign w_en        = w_inc & ~r_full;
    assign w_bin_next  = r_wr_bin + {{A{1'b0}}, w_en};
    assign w_gray_next = PW'(bin2gray(FUNC_W'(w_bin_next)));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits
    // inverted, remaining bits equal.
    assign w_full_ptr   = {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]};
    assign w_full_next  = (w_gray_next == w_full_ptr);
    assign w_level_next = w_bin_next - w_rd_bin;

    // Write pointers advance on every accepted write and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
        end else begin
            r_wr_bin  <= w_bin_next;
            r_wr_gray <= w_gray_next;
        end
    end

    // Status flags use the next pointer so full rises right after the filling write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_full  <= w_full_next;
            r_afull <= (w_level_next >= PW'(AFULL_THRESH));
            r_level <= w_level_next;
            // A dropped write sets the flag; setting takes priority over clearing.
            r_ovf   <= (w_inc & r_full) | (r_ovf & ~ovf_clr);
        end
    end

    assign w_addr      = r_wr_bin[A-1:0];
    assign wr_ptr_gray = r_wr_gray;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign w_level     = r_level;
    assign overflow    = r_ovf;

    // The exported Gray pointer may only ever move by a single bit.
    a_gray_one_bit: assert property (@(posedge clk) disable iff (!rst_n)
        (r_wr_gray != $past(r_wr_gray)) |-> $onehot(r_wr_gray ^ $past(r_wr_gray)));

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed scenarios followed by random traffic,
// all checked against a write-count / read-count model of the FIFO.
module tb_async_fifo_wr_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 4;
    localparam int THR   = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_inc = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [PW-1:0] rd_ptr_gray_sync = '0;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] wr_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] w_level;
    logic          overflow;

    async_fifo_wr_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (THR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .w_inc            (w_inc),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .ovf_clr          (ovf_clr),
        .w_en             (w_en),
        .w_addr           (w_addr),
        .wr_ptr_gray      (wr_ptr_gray),
        .full             (full),
        .almost_full      (almost_full),
        .w_level          (w_level),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: total writes accepted, reads visible, and the two flags that
    // depend on history.
    int m_wr  = 0;
    int m_rd  = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic logic [PW-1:0] gray_of(input int n);
        int b;
        b = n % (2 * DEPTH);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = m_wr - m_rd;
        chk({tag, ".w_addr"},      32'(w_addr),      32'(m_wr % DEPTH));
        chk({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 32'(gray_of(m_wr)));
        chk({tag, ".full"},        32'(full),        32'(m_full));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(lvl >= THR));
        chk({tag, ".w_level"},     32'(w_level),     32'(lvl));
        chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    endtask

    // One clock: apply inputs, check the combinational enable, clock, check state.
    task automatic step(input string tag, input bit inc, input int rd, input bit clr);
        w_inc            = inc;
        ovf_clr          = clr;
        rd_ptr_gray_sync = gray_of(rd);
        #1;
        chk({tag, ".w_en"}, 32'(w_en), 32'(inc && !m_full));
        @(posedge clk);
        if (inc && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (inc && !m_full) m_wr++;
        m_rd   = rd;
        m_full = ((m_wr - m_rd) == DEPTH);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between clock edges; returns one tick after an edge.
    task automatic do_reset(input string tag);
        w_inc            = 1'b0;
        ovf_clr          = 1'b0;
        rd_ptr_gray_sync = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".w_en"},        32'(w_en),        32'd0);
        chk({tag, ".w_addr"},      32'(w_addr),      32'd0);
        chk({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 32'd0);
        chk({tag, ".full"},        32'(full),        32'd0);
        chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, ".w_level"},     32'(w_level),     32'd0);
        chk({tag, ".overflow"},    32'(overflow),    32'd0);
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PW-1:0] fill_seq [8];
        logic [PW-1:0] prev_gray;
        int            hist[$];
        int            rd;
        fill_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

        @(posedge clk);
        #1;
        do_reset("reset0");

        // Fill with the read side idle.
        for (int i = 0; i < 8; i++) begin
            step("fill", 1'b1, 0, 1'b0);
            chk("fill.gray_seq", 32'(wr_ptr_gray), 32'(fill_seq[i]));
        end
        chk("fill.full_at_8", 32'(full), 32'd1);
        chk("fill.level_8",   32'(w_level), 32'd8);

        // Overflow and clear behaviour.
        step("ovf_set", 1'b1, 0, 1'b0);
        chk("ovf.ptr_hold", 32'(wr_ptr_gray), 32'd12);
        chk("ovf.flag",     32'(overflow),    32'd1);
        step("ovf_clr", 1'b0, 0, 1'b1);
        chk("ovf.cleared",  32'(overflow),    32'd0);
        step("ovf_setwins", 1'b1, 0, 1'b1);
        chk("ovf.set_wins", 32'(overflow),    32'd1);
        step("ovf_clr2", 1'b0, 0, 1'b1);

        // Read pointer jumps to binary 4 while full.
        step("drain", 1'b0, 4, 1'b0);
        chk("drain.full",  32'(full),        32'd0);
        chk("drain.level", 32'(w_level),     32'd4);
        chk("drain.afull", 32'(almost_full), 32'd0);

        // Wrap with the read pointer trailing by three cycles.
        do_reset("reset_wrap");
        hist.delete();
        for (int i = 0; i < 20; i++) begin
            hist.push_back(m_wr);
            rd = (hist.size() > 3) ? hist[hist.size() - 4] : 0;
            prev_gray = wr_ptr_gray;
            chk("wrap.addr_pre", 32'(w_addr), 32'(i % DEPTH));
            step("wrap", 1'b1, rd, 1'b0);
            chk("wrap.one_bit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'd1);
            if (i == 15) chk("wrap.gray_zero", 32'(wr_ptr_gray), 32'd0);
        end

        // Write and read advance together at level 5.
        do_reset("reset_sim");
        for (int i = 0; i < 5; i++) step("sim_fill", 1'b1, 0, 1'b0);
        step("sim", 1'b1, 1, 1'b0);
        chk("sim.level_5", 32'(w_level), 32'd5);

        // Reset in the middle of a fill at level 5.
        do_reset("reset_mid");
        step("post_rst", 1'b1, 0, 1'b0);
        chk("post_rst.gray1", 32'(wr_ptr_gray), 32'd1);

        // Random traffic: read side never overtakes writes it could have seen.
        do_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            rd = m_rd + int'($urandom_range(0, 2));
            if (rd > m_wr) rd = m_wr;
            step("rand", ($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the team's asynchronous FIFO, running entirely in the write clock domain.
- Accepts write requests and gates them into a memory write enable and address.
- Maintains the binary and Gray write pointers; the Gray pointer is exported to the read domain through the 2-flop pointer synchronizer.
- Consumes the read Gray pointer already synchronized into this domain and produces full, almost_full, a fill level and a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of two, >= 4.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), memory address width; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, FIFO_DEPTH-2, fill level at or above which almost_full asserts; range 1..FIFO_DEPTH.

Ports:
- clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- w_inc  input  1  write request from the producer.
- rd_ptr_gray_sync  input  ADDR_WIDTH+1  read Gray pointer, already synchronized into clk.
- ovf_clr  input  1  clears the sticky overflow flag.
- w_en  output  1  memory write enable.
- w_addr  output  ADDR_WIDTH  memory write address.
- wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer.
- full  output  1  FIFO full (registered).
- almost_full  output  1  level >= AFULL_THRESH (registered).
- w_level  output  ADDR_WIDTH+1  fill level as seen by the write side (registered).
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n.
- Reset values: wr_bin=0, wr_ptr_gray=0, full=0, almost_full=0, w_level=0, overflow=0; hence w_addr=0.
- w_en = w_inc & ~full (combinational). w_addr = wr_bin[ADDR_WIDTH-1:0] (direct from register).
- Pointer update:
  - wr_bin_next = wr_bin + w_en, modulo 2^(ADDR_WIDTH+1); wraps naturally.
  - wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
  - Both are registered every cycle. wr_ptr_gray is a pure register output with no combinational path, which is required for safe crossing.
- Full:
  - full_q <= (wr_gray_next == {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]}), where A = ADDR_WIDTH.
  - full asserts the cycle after the write that fills the FIFO, so there is no overflow under back-to-back writes.
- Level:
  - rd_bin = gray2bin(rd_ptr_gray_sync).
  - w_level <= wr_bin_next - rd_bin, modulo 2^(ADDR_WIDTH+1); range 0..FIFO_DEPTH.
  - almost_full <= (wr_bin_next - rd_bin) >= AFULL_THRESH.
- Pessimism: flags and level lag read progress by the 2-cycle synchronizer latency plus 1 register. full may stay high extra cycles after a read; it must never be low while the FIFO is actually full.
- Deassert: when rd_ptr_gray_sync advances while full and w_inc is low, full and w_level update on the next edge.
- Simultaneous write and read-pointer advance: both are applied in the same next-state computation; the level stays constant.
- Overflow:
  - overflow sets on w_inc & full; the write is dropped with no pointer change.
  - ovf_clr clears it. If set and clear happen in the same cycle, set wins.
- Wrap-around: after 2*FIFO_DEPTH writes, wr_bin returns to 0 and wr_ptr_gray returns to 0; the full comparison remains correct across the wrap.
- Reset mid-operation: all state returns to the reset values immediately and asynchronously. The read side must be reset concurrently; no recovery logic is included.
- Gray code: exactly one bit of wr_ptr_gray changes per increment (checked by assertion).

Decomposition:
- Shared package, fifo_pkg:
  - bin2gray and gray2bin functions, parameterized by width.
  - Pointer-width constant derived from FIFO_DEPTH.
- One sub-module: gray2bin_conv, a combinational XOR prefix chain. It is reused by the read-side controller.
- The synchronizer is instantiated outside this block, at the FIFO top level.

Test Plan:
1. Fill: reset, then rd_ptr_gray_sync=0 and w_inc=1 for 8 cycles.
   - wr_ptr_gray sequence 1,3,2,6,7,5,4,12.
   - full=1 after the 8th edge, w_level=8, almost_full=1 from level 6.
2. Overflow: continue the fill with 1 more w_inc.
   - w_en=0, pointer stays 12, overflow=1.
   - Pulse ovf_clr with w_inc=0 -> overflow=0. Pulse ovf_clr with w_inc=1 while full -> overflow stays 1.
3. Drain visibility: from full, set rd_ptr_gray_sync=6 (binary 4).
   - Next edge: full=0, w_level=4, almost_full=0.
4. Wrap: rd_ptr_gray_sync tracks wr_ptr_gray delayed by 3 cycles; write 20 times.
   - wr_bin wraps to 0 after 16 writes, w_addr cycles 0..7.
   - full is never set, and wr_ptr_gray changes exactly 1 bit per write.
5. Simultaneous: at level 5, w_inc=1 and rd_ptr_gray_sync advances by 1 in the same cycle -> w_level stays 5.
6. Reset mid-fill: assert rst_n low asynchronously at level 5, between clock edges.
   - All outputs go to 0 immediately.
   - After release, the first write produces wr_ptr_gray=1.
